// File: rtl/dtag_bist_pkg.sv
// Shared definitions for the D-cache tag-array march BIST controller:
// FSM states, the march-element table, mode encodings and default widths.
package dtag_bist_pkg;

  localparam int TW_DEF = 19;   // tag width
  localparam int IW_DEF = 9;    // set-index width
  localparam int SW     = 5;    // status width

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STOP = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5, ST_DRAIN, ST_DONE
  } state_e;

  // One march element: address direction, read/write patterns (replicated
  // across all data bits) and which operations the element performs.
  typedef struct packed {
    logic dn;
    logic rpat;
    logic wpat;
    logic rd;
    logic wr;
  } elem_t;

  function automatic elem_t elem_of(state_e s);
    elem_t e;
    e = '0;
    case (s)
      ST_M0: e = '{dn: 1'b0, rpat: 1'b0, wpat: 1'b0, rd: 1'b0, wr: 1'b1};
      ST_M1: e = '{dn: 1'b0, rpat: 1'b0, wpat: 1'b1, rd: 1'b1, wr: 1'b1};
      ST_M2: e = '{dn: 1'b0, rpat: 1'b1, wpat: 1'b0, rd: 1'b1, wr: 1'b1};
      ST_M3: e = '{dn: 1'b1, rpat: 1'b0, wpat: 1'b1, rd: 1'b1, wr: 1'b1};
      ST_M4: e = '{dn: 1'b1, rpat: 1'b1, wpat: 1'b0, rd: 1'b1, wr: 1'b1};
      ST_M5: e = '{dn: 1'b1, rpat: 1'b0, wpat: 1'b0, rd: 1'b1, wr: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic state_e next_elem(state_e s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DRAIN;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dtag_bist_addr_gen.sv
// Up/down address counter for the march. Counter is {index, set}.
// Ports: ld_zero_i / ld_max_i load the start address of an element,
// step_i advances one address in direction dn_i, last_o flags the final
// address of the element in the current direction.
module dtag_bist_addr_gen #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_zero_i,
  input  logic         ld_max_i,
  input  logic         step_i,
  input  logic         dn_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_zero_i)     cnt_d = '0;
    else if (ld_max_i) cnt_d = '1;
    else if (step_i)   cnt_d = dn_i ? cnt_q - W'(1) : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = dn_i ? (cnt_q == '0) : (cnt_q == '1);

endmodule

// File: rtl/dtag_bist_ctl.sv
// March C- style BIST controller for the D-cache tag/status array.
// Ports: clk/reset (async high); bist_mode selects off / run / run-stop-on-
// error; dtag_dout/stat_out are array read data (1-cycle latency);
// bist_tag_in/bist_stat_in/bist_addr/bist_wb_set_sel/bist_tag_we/
// bist_stat_we drive the array; bist_active/bist_done report progress;
// dtag_test_err_l is the sticky active-low error flag.
module dtag_bist_ctl
  import dtag_bist_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    bist_mode,
  input  logic [TW-1:0] dtag_dout,
  input  logic [4:0]    stat_out,
  output logic [TW-1:0] bist_tag_in,
  output logic [4:0]    bist_stat_in,
  output logic [IW-1:0] bist_addr,
  output logic          bist_wb_set_sel,
  output logic          bist_tag_we,
  output logic [4:0]    bist_stat_we,
  output logic          bist_active,
  output logic          bist_done,
  output logic          dtag_test_err_l
);

  localparam int DW = TW + SW;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;   // 0 = read, 1 = write in r/w elements
  logic            err_q, err_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic [DW-1:0]   exp_q, exp_d;

  elem_t           info, nxt_info;
  state_e          nxt;
  logic            run, stop;
  logic            cur_rd, cur_wr, addr_done, pat, mismatch, we;
  logic            start, ld_zero, ld_max, step, last;
  logic [IW:0]     cnt;

  assign run  = (bist_mode == MODE_RUN) || (bist_mode == MODE_STOP);
  assign stop = (bist_mode == MODE_STOP);

  assign info     = elem_of(state_q);
  assign nxt      = next_elem(state_q);
  assign nxt_info = elem_of(nxt);

  // Read-then-write elements use phase_q to pick the half; single-op
  // elements finish an address every cycle.
  assign cur_wr    = info.wr & (~info.rd | phase_q);
  assign cur_rd    = info.rd & (~info.wr | ~phase_q);
  assign addr_done = info.wr ? cur_wr : cur_rd;
  assign pat       = cur_wr ? info.wpat : (cur_rd ? info.rpat : 1'b0);

  assign mismatch = cmp_vld_q & ({dtag_dout, stat_out} != exp_q);

  // Enables fall combinationally on abort, and in stop mode the write that
  // coincides with the first mismatch is suppressed.
  assign we = cur_wr & run & ~(stop & mismatch);

  dtag_bist_addr_gen #(.W(IW + 1)) u_addr (
    .clk       (clk),
    .reset     (reset),
    .ld_zero_i (ld_zero),
    .ld_max_i  (ld_max),
    .step_i    (step),
    .dn_i      (info.dn),
    .cnt_o     (cnt),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start   = 1'b0;
    ld_zero = 1'b0;
    ld_max  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (run) begin
          state_d = ST_M0;
          start   = 1'b1;
          ld_zero = 1'b1;
        end
      end
      ST_DRAIN: state_d = run ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!run) state_d = ST_IDLE;
      default: begin
        if (!run) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
        end else if (stop && mismatch) begin
          state_d = ST_DONE;
          phase_d = 1'b0;
        end else begin
          if (info.rd && info.wr) phase_d = ~phase_q;
          if (addr_done) begin
            if (last) begin
              state_d = nxt;
              // Up elements start at 0, down elements at all-ones.
              if (nxt != ST_DRAIN) begin
                if (nxt_info.dn) ld_max  = 1'b1;
                else             ld_zero = 1'b1;
              end
            end else begin
              step = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    err_d     = err_q;
    if (start)         err_d = 1'b0;
    else if (mismatch) err_d = 1'b1;
    cmp_vld_d = cur_rd & run;
    exp_d     = cur_rd ? {DW{info.rpat}} : exp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      err_q     <= 1'b0;
      cmp_vld_q <= 1'b0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      cmp_vld_q <= cmp_vld_d;
      exp_q     <= exp_d;
    end
  end

  assign bist_tag_in     = {TW{pat}};
  assign bist_stat_in    = {SW{pat}};
  assign bist_addr       = cnt[IW:1];
  assign bist_wb_set_sel = cnt[0];
  assign bist_tag_we     = we;
  assign bist_stat_we    = {SW{we}};
  assign bist_active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bist_done       = (state_q == ST_DONE);
  assign dtag_test_err_l = ~err_q;

endmodule

// File: tb/tb_dtag_bist_ctl.sv
// Bench for dtag_bist_ctl: behavioural tag/status array with injectable
// stuck-at faults, directed march runs and hand-derived cycle numbers.
module tb_dtag_bist_ctl;

  localparam int TW = 19;
  localparam int IW = 9;
  localparam int NK = 12000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    bist_mode = 2'b00;
  logic [TW-1:0] dtag_dout;
  logic [4:0]    stat_out;
  logic [TW-1:0] bist_tag_in;
  logic [4:0]    bist_stat_in;
  logic [IW-1:0] bist_addr;
  logic          bist_wb_set_sel;
  logic          bist_tag_we;
  logic [4:0]    bist_stat_we;
  logic          bist_active;
  logic          bist_done;
  logic          dtag_test_err_l;

  always #5 clk = ~clk;

  dtag_bist_ctl #(.TW(TW), .IW(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .bist_mode       (bist_mode),
    .dtag_dout       (dtag_dout),
    .stat_out        (stat_out),
    .bist_tag_in     (bist_tag_in),
    .bist_stat_in    (bist_stat_in),
    .bist_addr       (bist_addr),
    .bist_wb_set_sel (bist_wb_set_sel),
    .bist_tag_we     (bist_tag_we),
    .bist_stat_we    (bist_stat_we),
    .bist_active     (bist_active),
    .bist_done       (bist_done),
    .dtag_test_err_l (dtag_test_err_l)
  );

  // ---------------- array model ----------------
  logic [TW+4:0] mem [0:1023];
  logic [TW+4:0] rd_q;
  int            fault = 0;
  int            n_wr_arr = 0;
  logic [9:0]    a_cur;

  assign a_cur = {bist_addr, bist_wb_set_sel};

  // 1: tag bit 7 of set1 index 0x1A5 stuck-at-1; 2: stat bit 2 at index 0 stuck-at-0
  function automatic logic [TW+4:0] flt(input logic [9:0] a, input logic [TW+4:0] d);
    logic [TW+4:0] r;
    r = d;
    if (fault == 1 && a == 10'h34B) r[5+7] = 1'b1;
    if (fault == 2 && a[9:1] == 9'd0) r[2] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bist_tag_we) begin
      mem[a_cur] <= {bist_tag_in, bist_stat_in};
      n_wr_arr   <= n_wr_arr + 1;
    end
    rd_q <= flt(a_cur, mem[a_cur]);
  end

  assign dtag_dout = rd_q[TW+4:5];
  assign stat_out  = rd_q[4:0];

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- per-cycle trace of one run ----------------
  logic [9:0]    tr_a   [NK+1];
  logic          tr_we  [NK+1];
  logic          tr_act [NK+1];
  logic          tr_err [NK+1];
  logic [TW-1:0] tr_tag [NK+1];
  int            k, done_k;

  // Sample #1 after each edge; sample i reflects state after the i-th edge
  // since the mode was applied. Stops at bist_done or at stop_k.
  task automatic run(input int stop_k);
    bit hit;
    hit = 1'b0; k = 0; done_k = 0;
    for (int i = 1; i <= NK; i++) begin
      @(posedge clk); #1;
      k = i;
      tr_a[i]   = a_cur;
      tr_we[i]  = bist_tag_we;
      tr_act[i] = bist_active;
      tr_err[i] = dtag_test_err_l;
      tr_tag[i] = bist_tag_in;
      if (bist_done && done_k == 0) done_k = i;
      if (bist_done || i == stop_k) begin hit = 1'b1; break; end
    end
    if (!hit) chk("run_timeout", 0, 1);
  endtask

  function automatic int cnt_we(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) if (tr_we[i]) c++;
    return c;
  endfunction

  function automatic int cnt_act(input int hi);
    int c;
    c = 0;
    for (int i = 1; i <= hi; i++) if (tr_act[i]) c++;
    return c;
  endfunction

  function automatic int first_err();
    for (int i = 1; i <= k; i++) if (tr_err[i] == 1'b0) return i;
    return 0;
  endfunction

  task automatic go_idle();
    bist_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, snap;
    logic [TW-1:0] ones;
    ones = '1;

    // reset values
    #23;
    chk("rst_active", bist_active, 0);
    chk("rst_done",   bist_done, 0);
    chk("rst_err_l",  dtag_test_err_l, 1);
    chk("rst_we",     {bist_tag_we, bist_stat_we}, 0);
    chk("rst_addr",   a_cur, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_active", bist_active, 0);

    // fault-free full march, mode 01
    bist_mode = 2'b01;
    run(0);
    chk("ff_m0_first", {tr_a[1], tr_we[1]}, {10'd0, 1'b1});
    chk("ff_m0_last",  {tr_a[1024], tr_we[1024]}, {10'd1023, 1'b1});
    chk("ff_m1_rd0",   {tr_a[1025], tr_we[1025], tr_tag[1025]}, {10'd0, 1'b0, {TW{1'b0}}});
    chk("ff_m1_wr0",   {tr_a[1026], tr_we[1026], tr_tag[1026]}, {10'd0, 1'b1, ones});
    chk("ff_m3_rd",    {tr_a[5121], tr_we[5121]}, {10'd1023, 1'b0});
    chk("ff_m3_wr",    {tr_a[5122], tr_we[5122], tr_tag[5122]}, {10'd1023, 1'b1, ones});
    chk("ff_m5_last",  {tr_a[10240], tr_we[10240], tr_act[10240]}, {10'd0, 1'b0, 1'b1});
    chk("ff_drain",    {tr_act[10241], tr_we[10241]}, {1'b1, 1'b0});
    chk("ff_done_k",   done_k, 10242);
    chk("ff_act_cnt",  cnt_act(k), 10241);
    chk("ff_wr_cnt",   cnt_we(1, k), 5120);
    chk("ff_err_l",    dtag_test_err_l, 1);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== '0) bad++;
    chk("ff_mem_d0", bad, 0);
    go_idle();
    chk("ff_to_idle", {bist_done, bist_active}, 0);

    // tag fault, mode 01: error seen in M1, march completes
    fault = 1;
    bist_mode = 2'b01;
    run(0);
    chk("f1_err_k",  first_err(), 2713);
    chk("f1_done_k", done_k, 10242);
    chk("f1_err_l",  dtag_test_err_l, 0);
    go_idle();

    // same fault, mode 11: stop one cycle after the mismatch
    bist_mode = 2'b11;
    run(0);
    chk("f1s_done_k",   done_k, 2713);
    chk("f1s_wr_pre",   cnt_we(1, 2711), 1867);
    chk("f1s_wr_after", cnt_we(2713, k), 0);
    chk("f1s_err_l",    dtag_test_err_l, 0);
    go_idle();

    // abort mid-M1 with error flag already low
    bist_mode = 2'b01;
    run(3000);
    bist_mode = 2'b00;
    #1;
    chk("ab_we_drop", {bist_tag_we, bist_stat_we}, 0);
    @(posedge clk); #1;
    chk("ab_idle", {bist_active, bist_done}, 0);
    chk("ab_err_keep", dtag_test_err_l, 0);
    bist_mode = 2'b01;
    run(6000);
    chk("rs_start", {tr_a[1], tr_we[1], tr_err[1]}, {10'd0, 1'b1, 1'b1});

    // asynchronous reset mid-M3
    #2;
    reset = 1'b1;
    #1;
    chk("ar_active", {bist_active, bist_done}, 0);
    chk("ar_we",     {bist_tag_we, bist_stat_we}, 0);
    chk("ar_addr",   a_cur, 0);
    chk("ar_data",   {bist_tag_in, bist_stat_in}, 0);
    chk("ar_err_l",  dtag_test_err_l, 1);
    snap = n_wr_arr;
    bist_mode = 2'b00;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("ar_untouched", n_wr_arr - snap, 0);
    chk("ar_idle", bist_active, 0);

    // status fault, mode 11: caught on first M2 read (index 0 set0)
    fault = 2;
    bist_mode = 2'b11;
    run(0);
    chk("f2_m2_rd",   {tr_a[3073], tr_we[3073]}, {10'd0, 1'b0});
    chk("f2_err_seq", {tr_err[3074], tr_err[3075]}, 2'b10);
    chk("f2_done_k",  done_k, 3075);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
